// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin front end for the word-organised data memory.
// Optional misalignment checking (m0_err/m1_err ports) is enabled by defining DM_ARB_ALIGN_CHK_EN.
`default_nettype none

module dm_arbiter #(
  parameter int ADDR_W  = 10,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m0_pc,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [31:0]       m1_pc,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
`ifdef DM_ARB_ALIGN_CHK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              mem_write,
  output logic [3:0]        mem_sig,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, state_next;
  logic        cmd_we;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata, cmd_pc;
  logic        owner;
  logic        rr;
  logic        win;
  logic        access;
  logic        bad;
  logic [3:0]  lane_sig;

  // rr names the requester that wins a tie.
  assign win    = m1_req && (!m0_req || rr);
  // A reset landing in the ACCESS cycle abandons the access entirely.
  assign access = (state == ACCESS) && !reset;

`ifdef DM_ARB_ALIGN_CHK_EN
  always_comb begin
    bad = 1'b0;
    case (cmd_size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = cmd_addr[0];
      default: bad = (cmd_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    lane_sig = 4'hF;
    case (cmd_size)
      2'd0:    lane_sig = 4'b0001 << cmd_addr[1:0];
      2'd1:    lane_sig = cmd_addr[1] ? 4'd9 : 4'd3;
      default: lane_sig = 4'hF;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (m0_req || m1_req) state_next = ACCESS;
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_we    <= 1'b0;
      cmd_size  <= 2'd0;
      cmd_addr  <= 32'd0;
      cmd_wdata <= 32'd0;
      cmd_pc    <= 32'd0;
      owner     <= 1'b0;
    end else if (state == IDLE && (m0_req || m1_req)) begin
      cmd_we    <= win ? m1_we    : m0_we;
      cmd_size  <= win ? m1_size  : m0_size;
      cmd_addr  <= win ? m1_addr  : m0_addr;
      cmd_wdata <= win ? m1_wdata : m0_wdata;
      cmd_pc    <= win ? m1_pc    : m0_pc;
      owner     <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr <= RR_INIT;
    else if (access) rr <= ~owner;
  end

  // Each rdata register only ever captures its own owner's accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
    end else begin
      m0_rvalid <= access && !owner;
      m1_rvalid <= access && owner;
      if (access && !owner) m0_rdata <= bad ? 32'd0 : mem_rdata;
      if (access && owner)  m1_rdata <= bad ? 32'd0 : mem_rdata;
    end
  end

`ifdef DM_ARB_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= access && !owner && bad;
      m1_err <= access && owner && bad;
    end
  end
`endif

  assign m0_gnt    = access && !owner;
  assign m1_gnt    = access && owner;
  assign mem_write = access && cmd_we && !bad;
  assign mem_sig   = mem_write ? lane_sig : 4'd0;
  assign mem_a     = cmd_addr[ADDR_W+1:2];
  assign mem_wdata = cmd_wdata;
  assign mem_addr  = cmd_addr;
  assign mem_pc    = cmd_pc;

endmodule

`default_nettype wire
